// File: rtl/ht1632_frame_tx_if.sv
// rtl/ht1632_frame_tx_if.sv - frame request, status and HT1632 pin bundle
interface ht1632_frame_tx_if #(
  parameter int FRAME_BITS = 394
);
  logic [FRAME_BITS-1:0] frame;
  logic [8:0]            nbits;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  overrun;
  logic                  cs;
  logic                  write;
  logic                  data;

  // Frame packer side: issues requests, observes status and pins
  modport master (
    output frame, nbits, start,
    input  busy, done, overrun, cs, write, data
  );

  // Transmitter side: owns the status flags and the matrix pins
  modport slave (
    input  frame, nbits, start,
    output busy, done, overrun, cs, write, data
  );
endinterface

// File: rtl/ht1632_frame_tx.sv
// rtl/ht1632_frame_tx.sv - HT1632 serial transmitter: init commands, then MSB-first frames
module ht1632_frame_tx #(
  parameter int          FRAME_BITS = 394,
  parameter int          CLK_DIV    = 50,
  parameter logic [11:0] CMD_SYS_EN = 12'h802,
  parameter logic [11:0] CMD_COM    = 12'h858,
  parameter logic [11:0] CMD_LED_ON = 12'h806
) (
  input logic              clk,
  input logic              RST,
  ht1632_frame_tx_if.slave bus
);

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [8:0]     FRAME_N  = 9'(FRAME_BITS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_WR_LO = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]            r_state;
  logic [DW-1:0]         r_div;
  logic [FRAME_BITS-1:0] r_shift;
  logic [8:0]            r_cnt;
  // Number of init commands already loaded; 3 means init is finished
  logic [1:0]            r_init_idx;
  // Set while the transaction in flight is a frame (not an init command)
  logic                  r_frame_tx;
  logic                  r_cs;
  logic                  r_write;
  logic                  r_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overrun;

  logic [2:0]            w_nstate;
  logic [DW-1:0]         w_ndiv;
  logic [FRAME_BITS-1:0] w_nshift;
  logic [8:0]            w_ncnt;
  logic [1:0]            w_ninit;
  logic                  w_nframe;
  logic                  w_ndone;
  logic                  w_div_end;
  logic                  w_req;
  logic                  w_accept;
  logic [8:0]            w_n;
  logic [8:0]            w_shamt;
  logic [11:0]           w_init_cmd;
  logic                  w_ncs;
  logic                  w_nwrite;
  logic                  w_ndata;

  assign w_div_end = (r_div == DIV_LAST);
  assign w_req     = bus.start && (bus.nbits != 9'd0);
  assign w_accept  = w_req && (r_state == S_IDLE);
  assign w_n       = (bus.nbits > FRAME_N) ? FRAME_N : bus.nbits;
  assign w_shamt   = FRAME_N - w_n;

  // Select the next init command from the number already sent
  always_comb begin
    case (r_init_idx)
      2'd0:    w_init_cmd = CMD_SYS_EN;
      2'd1:    w_init_cmd = CMD_COM;
      default: w_init_cmd = CMD_LED_ON;
    endcase
  end

  // Next-state logic; every state except IDLE lasts CLK_DIV cycles
  always_comb begin
    w_nstate = r_state;
    w_ndiv   = r_div + DW'(1);
    w_nshift = r_shift;
    w_ncnt   = r_cnt;
    w_ninit  = r_init_idx;
    w_nframe = r_frame_tx;
    w_ndone  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ndiv = '0;
        if (w_accept) begin
          w_nstate = S_SETUP;
          // Left-align so bit nbits-1 sits in the MSB and is sent first
          w_nshift = bus.frame << w_shamt;
          w_ncnt   = w_n;
          w_nframe = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_div_end) begin
          w_nstate = S_WR_LO;
          w_ndiv   = '0;
        end
      end
      S_WR_LO: begin
        if (w_div_end) begin
          w_nstate = S_WR_HI;
          w_ndiv   = '0;
        end
      end
      S_WR_HI: begin
        if (w_div_end) begin
          w_ndiv = '0;
          if (r_cnt > 9'd1) begin
            w_nstate = S_WR_LO;
            w_nshift = r_shift << 1;
            w_ncnt   = r_cnt - 9'd1;
          end else begin
            w_nstate = S_GAP;
            w_ncnt   = 9'd0;
          end
        end
      end
      S_GAP: begin
        if (w_div_end) begin
          w_ndiv = '0;
          if (r_init_idx != 2'd3) begin
            // Reset parks the block at the end of a GAP so init starts here
            w_nstate = S_SETUP;
            w_nshift = {w_init_cmd, {(FRAME_BITS-12){1'b0}}};
            w_ncnt   = 9'd12;
            w_ninit  = r_init_idx + 2'd1;
            w_nframe = 1'b0;
          end else begin
            w_nstate = S_IDLE;
            w_ndone  = r_frame_tx;
          end
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_ndiv   = '0;
      end
    endcase
  end

  // Pin levels decoded from the state being entered, so outputs are registered
  always_comb begin
    w_ncs    = !((w_nstate == S_SETUP) || (w_nstate == S_WR_LO) || (w_nstate == S_WR_HI));
    w_nwrite = (w_nstate != S_WR_LO);
    w_ndata  = ((w_nstate == S_WR_LO) || (w_nstate == S_WR_HI)) ? w_nshift[FRAME_BITS-1] : 1'b0;
  end

  // State, datapath and registered outputs; reset looks like the tail of a GAP
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= S_GAP;
      r_div      <= DIV_LAST;
      r_shift    <= '0;
      r_cnt      <= 9'd0;
      r_init_idx <= 2'd0;
      r_frame_tx <= 1'b0;
      r_cs       <= 1'b1;
      r_write    <= 1'b1;
      r_data     <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_div      <= w_ndiv;
      r_shift    <= w_nshift;
      r_cnt      <= w_ncnt;
      r_init_idx <= w_ninit;
      r_frame_tx <= w_nframe;
      r_cs       <= w_ncs;
      r_write    <= w_nwrite;
      r_data     <= w_ndata;
      r_busy     <= (w_nstate != S_IDLE);
      r_done     <= w_ndone;
      r_overrun  <= w_req && (r_state != S_IDLE);
    end
  end

  assign bus.cs      = r_cs;
  assign bus.write   = r_write;
  assign bus.data    = r_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_ht1632_frame_tx.sv
// tb/tb_ht1632_frame_tx.sv - queue-model bench for ht1632_frame_tx at CLK_DIV 3, 1 and 50
module tb_ht1632_frame_tx;

  localparam int FB = 394;

  logic          clk = 1'b0;
  logic          rst;
  logic [FB-1:0] frame_d;
  logic [8:0]    nbits_d;
  logic          start_d;
  logic [2:0]    cs_o, wr_o, dat_o, busy_o, done_o, ov_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 3 : (g == 1) ? 1 : 50;
    ht1632_frame_tx_if #(.FRAME_BITS(FB)) bus ();
    assign bus.frame = frame_d;
    assign bus.nbits = nbits_d;
    assign bus.start = start_d;
    assign cs_o[g]   = bus.cs;
    assign wr_o[g]   = bus.write;
    assign dat_o[g]  = bus.data;
    assign busy_o[g] = bus.busy;
    assign done_o[g] = bus.done;
    assign ov_o[g]   = bus.overrun;
    ht1632_frame_tx #(.FRAME_BITS(FB), .CLK_DIV(DIV)) u_dut (
      .clk (clk),
      .RST (rst),
      .bus (bus.slave)
    );
  end

  typedef struct packed {logic cs; logic wr; logic d; logic fin;} ent_t;

  int   vectors, miscompares, cyc;
  int   divs[3]     = '{3, 1, 50};
  int   init_len[3] = '{234, 78, 3900};
  int   lat394[3]   = '{2370, 790, 39500};
  ent_t mq [3][$];
  logic [2:0] e_cs, e_wr, e_d, e_busy, e_done, e_ov, pend, dflag;
  bit   armed;

  logic [FB-1:0] dsh[3];
  int            dnb[3];
  logic [2:0]    pw, pc, pb;
  logic [FB-1:0] bval [3][$];
  int            bnb  [3][$];
  int            done_cnt[3], done_at[3], ov_cnt[3], fall_at[3];

  int            st, e1;
  int            dsave[3], osave[3];
  logic [FB-1:0] f394, fr;
  logic [11:0]   cmds[3] = '{12'h802, 12'h858, 12'h806};

  task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ent_t mk(bit c, bit w, bit d, bit f);
    mk = {c, w, d, f};
  endfunction

  // Expected per-cycle pin waveform of one transaction, straight from the bit timing rules
  task automatic push_tx(input int k, input logic [FB-1:0] val, input int n, input bit fin);
    int dv = divs[k];
    for (int i = 0; i < dv; i++) mq[k].push_back(mk(0, 1, 0, 0));
    for (int b = n - 1; b >= 0; b--) begin
      for (int i = 0; i < dv; i++) mq[k].push_back(mk(0, 0, val[b], 0));
      for (int i = 0; i < dv; i++) mq[k].push_back(mk(0, 1, val[b], 0));
    end
    for (int i = 0; i < dv; i++) mq[k].push_back(mk(1, 1, 0, fin && (i == dv - 1)));
  endtask

  task automatic model_step(input int k);
    ent_t e;
    bit   go, wb;
    int   n;
    if (rst) begin
      mq[k].delete();
      e_cs[k] = 1; e_wr[k] = 1; e_d[k] = 0; e_busy[k] = 1; e_done[k] = 0; e_ov[k] = 0;
      pend[k] = 1; dflag[k] = 0;
    end else begin
      wb = e_busy[k];
      go = start_d && (nbits_d != 0);
      e_ov[k] = go && wb;
      if (pend[k]) begin
        for (int c = 0; c < 3; c++) push_tx(k, FB'(cmds[c]), 12, 0);
        pend[k] = 0;
      end else if (go && !wb) begin
        n = (nbits_d > FB) ? FB : int'(nbits_d);
        push_tx(k, frame_d, n, 1);
      end
      if (mq[k].size() > 0) begin
        e = mq[k].pop_front();
        e_cs[k] = e.cs; e_wr[k] = e.wr; e_d[k] = e.d; e_busy[k] = 1; e_done[k] = 0;
        dflag[k] = e.fin;
      end else begin
        e_cs[k] = 1; e_wr[k] = 1; e_d[k] = 0; e_busy[k] = 0;
        e_done[k] = dflag[k]; dflag[k] = 0;
      end
    end
  endtask

  task automatic monitor(input int k);
    if (armed) begin
      vectors++;
      if ({cs_o[k], wr_o[k], dat_o[k], busy_o[k], done_o[k], ov_o[k]} !==
          {e_cs[k], e_wr[k], e_d[k], e_busy[k], e_done[k], e_ov[k]}) begin
        miscompares++;
        $display("FAIL pins[%0d] cycle %0d: cs/wr/d/busy/done/ov got %b%b%b%b%b%b want %b%b%b%b%b%b",
                 k, cyc, cs_o[k], wr_o[k], dat_o[k], busy_o[k], done_o[k], ov_o[k],
                 e_cs[k], e_wr[k], e_d[k], e_busy[k], e_done[k], e_ov[k]);
      end
    end
    if (!cs_o[k] && !pw[k] && wr_o[k]) begin
      dsh[k] = {dsh[k][FB-2:0], dat_o[k]};
      dnb[k]++;
    end
    if (!pc[k] && cs_o[k]) begin
      bval[k].push_back(dsh[k]);
      bnb[k].push_back(dnb[k]);
      dsh[k] = '0;
      dnb[k] = 0;
    end
    if (done_o[k]) begin done_cnt[k]++; done_at[k] = cyc; end
    if (ov_o[k]) ov_cnt[k]++;
    if (pb[k] && !busy_o[k]) fall_at[k] = cyc;
    pw[k] = wr_o[k]; pc[k] = cs_o[k]; pb[k] = busy_o[k];
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [FB-1:0] f, input logic [8:0] n);
    step();
    frame_d = f; nbits_d = n; start_d = 1'b1; st = cyc + 1;
    step();
    start_d = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy_o !== 3'b000 && i < budget) begin step(); i++; end
    chk("idle_timeout", FB'(busy_o), '0);
  endtask

  task automatic clear_bursts();
    for (int k = 0; k < 3; k++) begin bval[k].delete(); bnb[k].delete(); end
  endtask

  task automatic check_init(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_bursts"}, FB'(bval[k].size()), FB'(3));
      for (int c = 0; c < 3 && c < bval[k].size(); c++) begin
        chk({tag, "_cmd"}, bval[k][c], FB'(cmds[c]));
        chk({tag, "_cmd_bits"}, FB'(bnb[k][c]), FB'(12));
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; armed = 0;
    rst = 1'b1; start_d = 1'b0; nbits_d = '0; frame_d = '0;
    pw = '1; pc = '1; pb = '1;
    for (int k = 0; k < 3; k++) begin
      dsh[k] = '0; dnb[k] = 0; done_cnt[k] = 0; done_at[k] = 0; ov_cnt[k] = 0; fall_at[k] = 0;
    end
    fork
      forever begin
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) model_step(k);
        armed = 1;
      end
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) monitor(k);
      end
    join_none

    // Reset values
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_cs", FB'(cs_o[k]), FB'(1));
      chk("rst_write", FB'(wr_o[k]), FB'(1));
      chk("rst_busy", FB'(busy_o[k]), FB'(1));
      chk("rst_done", FB'(done_o[k]), FB'(0));
    end
    clear_bursts();

    // Init sequence, with one start dropped during init
    rst = 1'b0; e1 = cyc + 1;
    repeat (20) step();
    pulse_start(FB'(12'hFFF), 9'd12);
    wait_idle(5000);
    check_init("init");
    for (int k = 0; k < 3; k++) begin
      chk("init_busy_len", FB'(fall_at[k] - e1), FB'(init_len[k]));
      chk("init_overrun", FB'(ov_cnt[k]), FB'(1));
      chk("init_no_done", FB'(done_cnt[k]), FB'(0));
    end

    // Full 394-bit frame, with a start dropped mid-frame
    clear_bursts();
    f394 = '0;
    for (int i = 0; i < 48; i++) f394[8*i +: 8] = 8'hA5;
    f394[393:391] = 3'b101;
    pulse_start(f394, 9'd394);
    e1 = st;
    repeat (300) step();
    pulse_start(~f394, 9'd5);
    wait_idle(45000);
    for (int k = 0; k < 3; k++) begin
      chk("f394_bursts", FB'(bval[k].size()), FB'(1));
      if (bval[k].size() > 0) begin
        chk("f394_stream", bval[k][0], f394);
        chk("f394_bits", FB'(bnb[k][0]), FB'(394));
      end
      chk("f394_done_cnt", FB'(done_cnt[k]), FB'(1));
      chk("f394_latency", FB'(done_at[k] - e1), FB'(lat394[k]));
      chk("f394_overrun", FB'(ov_cnt[k]), FB'(2));
    end

    // 12-bit frame, then a start issued in the done cycle of instance 0
    clear_bursts();
    pulse_start(FB'(12'hABC), 9'd12);
    e1 = st;
    for (int i = 0; i < 200 && !done_o[0]; i++) step();
    frame_d = FB'(12'h123); nbits_d = 9'd12; start_d = 1'b1;
    step();
    start_d = 1'b0;
    chk("start_in_done_cs", FB'(cs_o[0]), FB'(0));
    chk("abc_latency", FB'(done_at[0] - e1), FB'(78));
    wait_idle(5000);
    chk("abc_bursts", FB'(bval[0].size()), FB'(2));
    if (bval[0].size() == 2) begin
      chk("abc_stream", bval[0][0], FB'(12'hABC));
      chk("abc_bits", FB'(bnb[0][0]), FB'(12));
      chk("back2back_stream", bval[0][1], FB'(12'h123));
    end
    if (bval[2].size() > 0) chk("abc_stream_div50", bval[2][0], FB'(12'hABC));

    // nbits == 0 is ignored entirely
    clear_bursts();
    for (int k = 0; k < 3; k++) begin dsave[k] = done_cnt[k]; osave[k] = ov_cnt[k]; end
    pulse_start(f394, 9'd0);
    repeat (20) step();
    for (int k = 0; k < 3; k++) begin
      chk("n0_no_cs", FB'(bval[k].size()), FB'(0));
      chk("n0_no_done", FB'(done_cnt[k]), FB'(dsave[k]));
      chk("n0_no_overrun", FB'(ov_cnt[k]), FB'(osave[k]));
    end

    // nbits == 500 clamps to 394; reset lands at bit 100 of the CLK_DIV=50 instance
    clear_bursts();
    for (int i = 0; i < FB / 32 + 1; i++) fr[32*i +: 32] = $urandom();
    pulse_start(fr, 9'd500);
    e1 = st;
    repeat (100) step();
    pulse_start(f394, 9'd0);
    while (cyc < e1 + 50 * (1 + 2 * 100) + 10) step();
    dsave[2] = done_cnt[2];
    for (int k = 0; k < 2; k++) begin
      chk("n500_bursts", FB'(bval[k].size()), FB'(1));
      if (bval[k].size() > 0) begin
        chk("n500_bits", FB'(bnb[k][0]), FB'(394));
        chk("n500_stream", bval[k][0], fr);
      end
    end
    rst = 1'b1;
    step();
    chk("midrst_cs", FB'(cs_o[2]), FB'(1));
    chk("midrst_write", FB'(wr_o[2]), FB'(1));
    repeat (2) step();
    clear_bursts();
    rst = 1'b0;
    wait_idle(5000);
    check_init("reinit");
    chk("midrst_no_done", FB'(done_cnt[2]), FB'(dsave[2]));

    // Randomized requests, overlapping freely; the queue model checks every cycle
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < FB / 32 + 1; i++) fr[32*i +: 32] = $urandom();
      repeat ($urandom_range(0, 200)) step();
      pulse_start(fr, 9'($urandom_range(0, 60)));
    end
    wait_idle(20000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
